// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encoding, score width and BCD limit.
package game_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam int unsigned SCORE_W = 4;
  localparam logic [SCORE_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StArm  = S_ARM,
    StPlay = S_PLAY,
    StOver = S_OVER
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, then a stability counter.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   btn_in - raw asynchronous button, active-high
//   level  - debounced level
//   rise   - one-cycle pulse on each 0->1 change of level
module btn_debounce
  import game_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter tracks consecutive synchronized samples that disagree with the current level;
  // any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer in front of the countdown timer: button debouncing, 1 Hz divider,
// IDLE/ARM/PLAY/OVER state machine and a saturating two-digit BCD hit score.
// Ports:
//   clk, rst             - system clock, asynchronous active-low reset
//   start_btn, hit_btn   - raw push-buttons, active-high
//   stop                 - round-over flag from the timer (asynchronous here)
//   clk_1hz              - divided clock to the timer, 50% duty
//   tmr_rst_n            - active-low reset to the timer
//   inGame, over         - state indications for PLAY and OVER
//   score1, score2       - BCD tens and ones digits of the score
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DIV       = 25_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               hit_btn,
  input  logic               stop,
  output logic               clk_1hz,
  output logic               tmr_rst_n,
  output logic               inGame,
  output logic               over,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

  logic start_rise, hit_rise;
  logic start_level_unused, hit_level_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
    .clk   (clk),
    .rst   (rst),
    .btn_in(start_btn),
    .level (start_level_unused),
    .rise  (start_rise)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_hit_db (
    .clk   (clk),
    .rst   (rst),
    .btn_in(hit_btn),
    .level (hit_level_unused),
    .rise  (hit_rise)
  );

  state_e             state_q, state_d;
  logic [1:0]         arm_cnt_q, arm_cnt_d;
  logic [DivW-1:0]    div_cnt_q, div_cnt_d;
  logic               clk_1hz_q, clk_1hz_d;
  logic               stop_s1_q, stop_s2_q, stop_prev_q;
  logic               stop_rise;
  logic               tmr_rst_n_q, tmr_rst_n_d;
  logic               in_game_q, in_game_d;
  logic               over_q, over_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;

  assign stop_rise = stop_s2_q & ~stop_prev_q;

  // Divider is held at phase 0 throughout ARM so the timer's first tick is a full period
  // after play begins.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    clk_1hz_d = clk_1hz_q;
    if (state_q == StArm) begin
      div_cnt_d = '0;
      clk_1hz_d = 1'b0;
    end else if (div_cnt_q == DivW'(DIV - 1)) begin
      div_cnt_d = '0;
      clk_1hz_d = ~clk_1hz_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    tmr_rst_n_d = 1'b1;
    case (state_q)
      StIdle: if (start_rise) state_d = StArm;
      StArm: begin
        // Wait two cycles past the timer reset pulse so the synchronized stop reflects the
        // timer after reset, not a stale high from the previous round.
        if (arm_cnt_q == 2'd2) begin
          if (!stop_s2_q) state_d = StPlay;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      StPlay: begin
        if (hit_rise && !(score1_q == BCD_MAX && score2_q == BCD_MAX)) begin
          if (score2_q == BCD_MAX) begin
            score2_d = '0;
            score1_d = score1_q + 1'b1;
          end else begin
            score2_d = score2_q + 1'b1;
          end
        end
        if (stop_rise) state_d = StOver;
      end
      StOver: if (start_rise) state_d = StArm;
      default: state_d = StIdle;
    endcase

    // Entering ARM: one-cycle timer reset, fresh score, restart the settle count.
    if (state_q != StArm && state_d == StArm) begin
      arm_cnt_d   = '0;
      score1_d    = '0;
      score2_d    = '0;
      tmr_rst_n_d = 1'b0;
    end

    in_game_d = (state_d == StPlay);
    over_d    = (state_d == StOver);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      arm_cnt_q   <= '0;
      div_cnt_q   <= '0;
      clk_1hz_q   <= 1'b0;
      stop_s1_q   <= 1'b0;
      stop_s2_q   <= 1'b0;
      stop_prev_q <= 1'b0;
      tmr_rst_n_q <= 1'b0;
      in_game_q   <= 1'b0;
      over_q      <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      div_cnt_q   <= div_cnt_d;
      clk_1hz_q   <= clk_1hz_d;
      stop_s1_q   <= stop;
      stop_s2_q   <= stop_s1_q;
      stop_prev_q <= stop_s2_q;
      tmr_rst_n_q <= tmr_rst_n_d;
      in_game_q   <= in_game_d;
      over_q      <= over_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
    end
  end

  assign clk_1hz   = clk_1hz_q;
  assign tmr_rst_n = tmr_rst_n_q;
  assign inGame    = in_game_q;
  assign over      = over_q;
  assign score1    = score1_q;
  assign score2    = score2_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl with DIV=4, DB_CYCLES=3. A behavioural model (sample histories,
// integer score, cycle counts) predicts every output each cycle; directed scenarios add
// literal expectations. A small timer stand-in raises stop on request and clears it
// whenever tmr_rst_n is low.
module tb_game_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned DB  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       hit_btn = 1'b0;
  logic       stop_q = 1'b0;
  logic       stop_set = 1'b0;
  logic       clk_1hz, tmr_rst_n, inGame, over;
  logic [3:0] score1, score2;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  game_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .hit_btn  (hit_btn),
    .stop     (stop_q),
    .clk_1hz  (clk_1hz),
    .tmr_rst_n(tmr_rst_n),
    .inGame   (inGame),
    .over     (over),
    .score1   (score1),
    .score2   (score2)
  );

  // Timer stand-in: stop is a flop set on request, cleared by the timer reset.
  always @(posedge clk or negedge tmr_rst_n) begin
    if (!tmr_rst_n) stop_q <= 1'b0;
    else if (stop_set) stop_q <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MIdle, MArm, MPlay, MOver} mst_e;
  mst_e        m_st;
  int          m_score, m_j, m_age;
  logic        m_tmr;
  logic        m_start_lvl, m_hit_lvl, m_start_rise, m_hit_rise;
  logic [15:0] h_start, h_hit, h_stop;  // bit i = raw sample taken i+1 edges ago

  // Level changes once the last DB synchronized samples (raw delayed two edges) all differ.
  function automatic logic flips(input logic [15:0] h, input logic lvl);
    for (int i = 1; i <= int'(DB); i++) if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic s_rise, k_rise, stop_sync, stop_edge;
    if (!rst) begin
      m_st = MIdle; m_score = 0; m_j = 0; m_age = 0; m_tmr = 1'b0;
      m_start_lvl = 1'b0; m_hit_lvl = 1'b0; m_start_rise = 1'b0; m_hit_rise = 1'b0;
      h_start = '0; h_hit = '0; h_stop = '0;
    end else begin
      s_rise    = m_start_rise;
      k_rise    = m_hit_rise;
      stop_sync = h_stop[1];
      stop_edge = h_stop[1] & ~h_stop[2];
      if (m_st == MArm) m_j = 0;
      else m_j++;
      case (m_st)
        MIdle, MOver: if (s_rise) begin m_st = MArm; m_age = 0; m_score = 0; end
        MArm: if (m_age >= 2 && !stop_sync) m_st = MPlay; else m_age++;
        MPlay: begin
          if (k_rise && m_score < 99) m_score++;
          if (stop_edge) m_st = MOver;
        end
        default: ;
      endcase
      m_tmr = !(m_st == MArm && m_age == 0);
      m_start_rise = 1'b0;
      if (flips(h_start, m_start_lvl)) begin
        m_start_lvl  = ~m_start_lvl;
        m_start_rise = m_start_lvl;
      end
      m_hit_rise = 1'b0;
      if (flips(h_hit, m_hit_lvl)) begin
        m_hit_lvl  = ~m_hit_lvl;
        m_hit_rise = m_hit_lvl;
      end
      h_start = {h_start[14:0], start_btn};
      h_hit   = {h_hit[14:0], hit_btn};
      h_stop  = {h_stop[14:0], stop_q};
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("clk_1hz", clk_1hz, (m_j / int'(DIV)) % 2);
      chk("tmr_rst_n", tmr_rst_n, m_tmr);
      chk("inGame", inGame, m_st == MPlay);
      chk("over", over, m_st == MOver);
      chk("score1", score1, m_score / 10);
      chk("score2", score2, m_score % 10);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_hit();
    hit_btn = 1'b1;
    wait_cycles(4);
    hit_btn = 1'b0;
    wait_cycles(6);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

  initial begin : stim
    int   toggles, first_play, lows, first_over;
    logic prev;
    #1 rst = 1'b0;
    wait_cycles(3);
    chk("reset_tmr_rst_n", tmr_rst_n, 0);
    chk("reset_inGame", inGame, 0);
    chk("reset_score", {score1, score2}, 0);
    chk("reset_clk_1hz", clk_1hz, 0);
    check_en = 1'b1;
    rst = 1'b1;
    wait_cycles(2);
    chk("idle_tmr_rst_n", tmr_rst_n, 1);

    toggles = 0;
    prev = clk_1hz;
    for (int i = 0; i < 16; i++) begin
      wait_cycles(1);
      if (clk_1hz != prev) toggles++;
      prev = clk_1hz;
    end
    chk("idle_divider_toggles", toggles, 4);
    wait_cycles(32);
    chk("idle_inGame", inGame, 0);

    // Two-cycle start press is too short to debounce.
    start_btn = 1'b1;
    wait_cycles(2);
    start_btn = 1'b0;
    wait_cycles(10);
    chk("short_start_tmr_rst_n", tmr_rst_n, 1);
    chk("short_start_inGame", inGame, 0);

    // Start held 10 cycles: rise after 5 cycles, one timer-reset cycle, PLAY 4 cycles later.
    first_play = -1;
    lows = 0;
    start_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      wait_cycles(1);
      if (i == 10) start_btn = 1'b0;
      if (!tmr_rst_n) lows++;
      if (inGame && first_play < 0) first_play = i;
    end
    chk("arm_tmr_low_cycles", lows, 1);
    chk("arm_to_play_latency", first_play, 9);

    for (int i = 0; i < 12; i++) press_hit();
    hit_btn = 1'b1;
    wait_cycles(2);
    hit_btn = 1'b0;
    wait_cycles(6);
    chk("twelve_hits_score", {score1, score2}, 8'h12);

    // Synchronized stop edge lands in the same cycle as the hit rise.
    first_over = -1;
    hit_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      wait_cycles(1);
      if (i == 2) stop_set = 1'b1;
      if (i == 3) stop_set = 1'b0;
      if (i == 4) hit_btn = 1'b0;
      if (over && first_over < 0) first_over = i;
    end
    chk("stop_hit_over_latency", first_over, 6);
    chk("stop_hit_score", {score1, score2}, 8'h13);
    press_hit();
    chk("over_hit_ignored", {score1, score2}, 8'h13);

    start_btn = 1'b1;
    wait_cycles(6);
    start_btn = 1'b0;
    wait_cycles(10);
    chk("restart_inGame", inGame, 1);
    chk("restart_score", {score1, score2}, 0);

    for (int i = 0; i < 105; i++) press_hit();
    chk("saturated_score", {score1, score2}, 8'h99);
    chk("saturated_inGame", inGame, 1);

    // Asynchronous reset mid-round.
    #2 rst = 1'b0;
    #1;
    chk("async_tmr_rst_n", tmr_rst_n, 0);
    chk("async_inGame", inGame, 0);
    chk("async_over", over, 0);
    chk("async_score", {score1, score2}, 0);
    chk("async_clk_1hz", clk_1hz, 0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(5);
    chk("post_reset_tmr_rst_n", tmr_rst_n, 1);
    press_hit();
    chk("post_reset_idle_inGame", inGame, 0);
    chk("post_reset_idle_score", {score1, score2}, 0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the board, directly upstream of the 30-second countdown timer. It debounces the start and hit buttons and divides the system clock to produce `clk_1hz`. It runs the IDLE/ARM/PLAY/OVER state machine that drives the timer's `inGame` and reset inputs, and it keeps a two-digit BCD hit score. The timer's `stop` output is fed back here to end the round.

## Interface
Parameters:
- `DIV`, default 25_000_000: `clk` cycles per half-period of `clk_1hz`. The default gives 1 Hz from 50 MHz.
- `DB_CYCLES`, default 1_000_000: number of consecutive stable synchronized samples required for a button level change.

Ports:
- `clk` input, 1 bit: system clock. It is the only clock in this block.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `start_btn` input, 1 bit: raw start push-button, active-high, asynchronous.
- `hit_btn` input, 1 bit: raw player push-button, active-high, asynchronous.
- `stop` input, 1 bit: round-over flag from the timer, 2-flop synchronized here.
- `clk_1hz` output, 1 bit: divided clock to the timer, 50% duty cycle.
- `tmr_rst_n` output, 1 bit: active-low reset to the timer's `rst`.
- `inGame` output, 1 bit: high only while in PLAY.
- `over` output, 1 bit: high only while in OVER.
- `score1` output, 4 bits: BCD tens digit of the score.
- `score2` output, 4 bits: BCD ones digit of the score.

## Operation
- Reset values: state IDLE, `clk_1hz`=0, divider count 0, `tmr_rst_n`=0, `inGame`=0, `over`=0, `score1`=0, `score2`=0, debouncer levels 0. While `rst` is low the timer is held in reset.
- All outputs are registered. There is no combinational path from any input to any output.
- Divider: counts 0..DIV-1. `clk_1hz` toggles and the count returns to 0 on the cycle the count equals DIV-1. The divider is free-running except that it is cleared to count 0 with `clk_1hz`=0 while in ARM.
- Debouncer (applies to each button): 2-flop synchronizer followed by a stability counter. The debounced level takes the synchronized value after DB_CYCLES consecutive samples that differ from the current level. A one-cycle `rise` pulse is produced on each 0→1 level change.
- State transitions:
  - IDLE → ARM on a start `rise`.
  - ARM: `tmr_rst_n`=0 on the first ARM cycle and 1 afterwards. Score is cleared to 00 on entry. ARM → PLAY on the first cycle after the first ARM cycle in which synchronized `stop`=0.
  - PLAY: each hit `rise` increments the score as BCD. The ones digit 9 wraps to 0 and carries into the tens digit. The score saturates at 99, and further hits leave it unchanged. PLAY → OVER on a 0→1 edge of synchronized `stop`.
  - OVER: the score is held. OVER → ARM on a start `rise`.
- Ignored events: start `rise` in ARM or PLAY; hit `rise` in IDLE, ARM or OVER.
- Simultaneous hit `rise` and `stop` edge in PLAY: the hit is counted and the state moves to OVER in the same cycle.
- `rst` asserted mid-round: all state returns to reset values immediately, regardless of state.
- `tmr_rst_n` is 1 in every state except during `rst` and the first ARM cycle.

## Timing
- Button to `rise` pulse latency: exactly DB_CYCLES+2 `clk` cycles from the first cycle the raw input is sampled high, provided the input is held stable.
- Start `rise` in cycle N:
  - state=ARM and `tmr_rst_n`=0 in cycle N+1.
  - `tmr_rst_n`=1 in cycle N+2.
  - PLAY and `inGame`=1 no earlier than cycle N+4, because the timer's `stop` must first clear and pass through the 2-flop synchronizer.
- Hit `rise` in cycle N: the updated score is visible in cycle N+1.
- `stop` rising at the pin in cycle N: `inGame`=0 and `over`=1 in cycle N+3 (2 cycles of synchronization plus 1 cycle of edge register).
- First `clk_1hz` rising edge after ARM exit: DIV cycles after the ARM exit.

## Structure
- Shared package `game_pkg` contains:
  - State encoding localparams: S_IDLE=2'd0, S_ARM=2'd1, S_PLAY=2'd2, S_OVER=2'd3.
  - BCD_MAX=4'd9.
  - Score width SCORE_W=4.
- Sub-module `btn_debounce`, instantiated twice (start and hit):
  - Parameter DB_CYCLES.
  - Ports: `clk`, `rst`, `btn_in`, `level`, `rise`.
- Divider, FSM and BCD score counter are implemented inline in `game_ctrl`.

## Test plan
All scenarios use DIV=4 and DB_CYCLES=3.
- Reset, then idle for 50 cycles → `tmr_rst_n`=0 during reset and 1 afterwards; `inGame`=0; score 00; state stays IDLE; `clk_1hz` toggles every 4 cycles.
- Start held 10 cycles, with a timer model whose `stop` clears on `tmr_rst_n` → exactly one `tmr_rst_n` low cycle, then `inGame`=1 at N+4; a start held 2 cycles produces no `rise` and no transition.
- 12 clean hits in PLAY → score1=1, score2=2; a 2-cycle glitch on `hit_btn` does not count.
- 105 hits in PLAY → score saturates at score1=9, score2=9.
- `stop` asserted in the same cycle as a hit `rise` → the hit is counted and `over`=1 three cycles later; a further hit leaves the score unchanged; a start press returns to ARM and clears the score to 00.
- `rst` pulled low mid-PLAY → all outputs return to reset values asynchronously; after release, state is IDLE.
